// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: turns hazard flags and memory handshakes into
// per-stage write enables, bubble strobes and fetch abort, plus watchdog and perf counters.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_use_haz,
    input  logic             control_haz,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic             mem_wb_flush,
    output logic             imem_abort,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [TMR_W-1:0] wait_tmr;
    logic             data_wait;
    logic             redirect;

    assign data_wait = dmem_req && !dmem_ready;
    assign redirect  = !data_wait && control_haz;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state: only a data wait or an accepted redirect leaves RUN
    always_comb begin
        next_state = ST_RUN;
        if (data_wait) begin
            next_state = ST_DWAIT;
        end else if (control_haz) begin
            next_state = ST_REDIR;
        end
    end

    // Enables and strobes, strict priority; REDIR masks load-use since DE holds a bubble
    always_comb begin
        pc_we        = 1'b1;
        if_de_we     = 1'b1;
        de_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_de_flush  = 1'b0;
        de_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        imem_abort   = 1'b0;
        if (RST) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_de_flush  = 1'b1;
            de_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            imem_abort   = 1'b1;
        end else if (data_wait) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (control_haz) begin
            if_de_flush = 1'b1;
            de_ex_flush = 1'b1;
            imem_abort  = !imem_ready;
        end else if (load_use_haz && (state != ST_REDIR)) begin
            pc_we       = 1'b0;
            if_de_we    = 1'b0;
            de_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_we       = 1'b0;
            if_de_flush = 1'b1;
        end
    end

    // Memory-wait watchdog; the error is sticky until reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_tmr    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if ((state != ST_DWAIT) && (next_state == ST_DWAIT)) begin
                wait_tmr <= '0;
            end else if ((state == ST_DWAIT) && (wait_tmr != TMR_W'(TIMEOUT))) begin
                wait_tmr <= wait_tmr + TMR_W'(1);
            end
            if ((state == ST_DWAIT) && (wait_tmr == TMR_W'(TIMEOUT - 1))) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating performance counters, clear wins over increment
    always_ff @(posedge CLK) begin
        if (RST || cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with TIMEOUT=4 and CNT_W=4.
module tb_pipe_stall_ctrl;

    localparam logic [7:0] V_NORM  = 8'b1111_0000;
    localparam logic [7:0] V_RST   = 8'b0000_1111;
    localparam logic [7:0] V_LU    = 8'b0011_0100;
    localparam logic [7:0] V_REDIR = 8'b1111_1100;
    localparam logic [7:0] V_REDAB = 8'b1111_1101;
    localparam logic [7:0] V_DWAIT = 8'b0000_0010;
    localparam logic [7:0] V_FMISS = 8'b0111_1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       load_use_haz = 1'b0;
    logic       control_haz = 1'b0;
    logic       imem_ready = 1'b1;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       pc_we, if_de_we, de_ex_we, ex_mem_we;
    logic       if_de_flush, de_ex_flush, mem_wb_flush, imem_abort;
    logic       mem_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    logic [7:0] outs;

    int tests = 0;
    int fails = 0;

    pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .load_use_haz(load_use_haz), .control_haz(control_haz),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .cnt_clr(cnt_clr),
        .pc_we(pc_we), .if_de_we(if_de_we), .de_ex_we(de_ex_we), .ex_mem_we(ex_mem_we),
        .if_de_flush(if_de_flush), .de_ex_flush(de_ex_flush), .mem_wb_flush(mem_wb_flush),
        .imem_abort(imem_abort), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    assign outs = {pc_we, if_de_we, de_ex_we, ex_mem_we,
                   if_de_flush, de_ex_flush, mem_wb_flush, imem_abort};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        load_use_haz = 1'b0; control_haz = 1'b0; imem_ready = 1'b1;
        dmem_req = 1'b0; dmem_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        dmem_req = 1'b1; dmem_ready = 1'b0; control_haz = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_RST) begin fails++; $display("FAIL reset_outs: got %b want %b", outs, V_RST); end
        tick(); tick();
        tests++;
        if ({stall_cnt, flush_cnt, mem_timeout} !== 9'd0) begin
            fails++; $display("FAIL reset_regs: stall %0d flush %0d to %b want 0", stall_cnt, flush_cnt, mem_timeout);
        end
        idle_inputs();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            tests++;
            if (outs !== V_NORM) begin fails++; $display("FAIL idle_outs[%0d]: got %b want %b", i, outs, V_NORM); end
            tick();
        end
        tests++;
        if (stall_cnt !== 4'd0) begin fails++; $display("FAIL idle_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        apply_reset();
        load_use_haz = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_LU) begin fails++; $display("FAIL lu_outs: got %b want %b", outs, V_LU); end
        tick();
        load_use_haz = 1'b0;
        @(negedge CLK);
        tests++;
        if (outs !== V_NORM) begin fails++; $display("FAIL lu_after: got %b want %b", outs, V_NORM); end
        tick();
        tests++;
        if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_redirect_load_use();
        apply_reset();
        control_haz = 1'b1; load_use_haz = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_REDIR) begin fails++; $display("FAIL redir_lu_c1: got %b want %b", outs, V_REDIR); end
        tick();
        control_haz = 1'b0;
        @(negedge CLK);
        tests++;
        if (outs !== V_NORM) begin fails++; $display("FAIL redir_mask_c2: got %b want %b", outs, V_NORM); end
        tick();
        @(negedge CLK);
        tests++;
        if (outs !== V_LU) begin fails++; $display("FAIL redir_lu_c3: got %b want %b", outs, V_LU); end
        tick();
        load_use_haz = 1'b0;
        tests++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            fails++; $display("FAIL redir_lu_cnts: flush %0d stall %0d want 1 1", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_dwait_redirect();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0; control_haz = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++;
            if (outs !== V_DWAIT) begin fails++; $display("FAIL dwait_outs[%0d]: got %b want %b", i, outs, V_DWAIT); end
            tick();
        end
        dmem_ready = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_REDIR) begin fails++; $display("FAIL dwait_release: got %b want %b", outs, V_REDIR); end
        tick();
        idle_inputs();
        @(negedge CLK);
        tests++;
        if (outs !== V_NORM) begin fails++; $display("FAIL dwait_after: got %b want %b", outs, V_NORM); end
        tick();
        tests++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
            fails++; $display("FAIL dwait_cnts: flush %0d stall %0d want 1 3", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_fetch_miss();
        apply_reset();
        imem_ready = 1'b0;
        @(negedge CLK);
        tests++;
        if (outs !== V_FMISS) begin fails++; $display("FAIL fmiss_outs: got %b want %b", outs, V_FMISS); end
        tick();
        control_haz = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_REDAB) begin fails++; $display("FAIL redir_abort: got %b want %b", outs, V_REDAB); end
        tick();
        control_haz = 1'b0; imem_ready = 1'b0; load_use_haz = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_FMISS) begin fails++; $display("FAIL redir_fmiss: got %b want %b", outs, V_FMISS); end
        tick();
        idle_inputs();
        tests++;
        if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin
            fails++; $display("FAIL fmiss_cnts: stall %0d flush %0d want 2 1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++;
            if (mem_timeout !== (k >= 5)) begin
                fails++; $display("FAIL wdog_rise[%0d]: got %b want %b", k, mem_timeout, (k >= 5));
            end
        end
        dmem_ready = 1'b1;
        tick();
        idle_inputs();
        tick(); tick();
        tests++;
        if (mem_timeout !== 1'b1) begin fails++; $display("FAIL wdog_sticky: got %b want 1", mem_timeout); end
        tests++;
        if (stall_cnt !== 4'd6) begin fails++; $display("FAIL wdog_stall_cnt: got %0d want 6", stall_cnt); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests++;
        if (mem_timeout !== 1'b0) begin fails++; $display("FAIL wdog_reset: got %b want 0", mem_timeout); end
    endtask

    task automatic test_reset_mid_state();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        RST = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_RST) begin fails++; $display("FAIL mid_dwait_rst: got %b want %b", outs, V_RST); end
        tick();
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        tests++;
        if (outs !== V_NORM) begin fails++; $display("FAIL mid_dwait_after: got %b want %b", outs, V_NORM); end
        tick();
        control_haz = 1'b1;
        tick();
        control_haz = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        load_use_haz = 1'b1;
        @(negedge CLK);
        tests++;
        if (outs !== V_LU) begin fails++; $display("FAIL mid_redir_after: got %b want %b", outs, V_LU); end
        tick();
        idle_inputs();
    endtask

    task automatic test_saturation();
        apply_reset();
        load_use_haz = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall_cnt: got %0d want 15", stall_cnt); end
        cnt_clr = 1'b1;
        tick();
        tests++;
        if (stall_cnt !== 4'd0) begin fails++; $display("FAIL clr_stall_cnt: got %0d want 0", stall_cnt); end
        cnt_clr = 1'b0;
        tick();
        tests++;
        if (stall_cnt !== 4'd1) begin fails++; $display("FAIL post_clr_cnt: got %0d want 1", stall_cnt); end
        idle_inputs();
    endtask

    initial begin
        tick();
        test_reset();
        test_load_use();
        test_redirect_load_use();
        test_dwait_redirect();
        test_fetch_miss();
        test_watchdog();
        test_reset_mid_state();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Sequencing controller for the 5-stage pipeline. Each cycle it converts the hazard flags (load-use, control redirect) and the instruction/data memory handshakes into per-stage register write enables, bubble/flush strobes and a fetch abort. It tracks memory-wait cycles with a watchdog, and keeps saturating stall/flush performance counters. It sits between the hazard-detection logic, the caches and the pipeline registers.

## Interface
- `TIMEOUT`, default 1023: DWAIT cycles before `mem_timeout` sets.
- `CNT_W`, default 16: width of the performance counters.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `load_use_haz` in 1: load in EX feeds the instruction in DE.
- `control_haz` in 1: taken branch or jump resolved in EX (pc_source != 0).
- `imem_ready` in 1: fetch data valid this cycle.
- `dmem_req` in 1: load or store in MEM this cycle.
- `dmem_ready` in 1: data memory completes the MEM access this cycle.
- `cnt_clr` in 1: synchronous clear of both counters.
- `pc_we` out 1: PC register write enable.
- `if_de_we` out 1: IF/DE register write enable.
- `de_ex_we` out 1: DE/EX register write enable.
- `ex_mem_we` out 1: EX/MEM register write enable.
- `if_de_flush` out 1: load a bubble into IF/DE.
- `de_ex_flush` out 1: load a bubble into DE/EX.
- `mem_wb_flush` out 1: load a bubble into MEM/WB.
- `imem_abort` out 1: cancel the outstanding fetch.
- `mem_timeout` out 1: sticky watchdog error.
- `stall_cnt` out CNT_W: cycles with `pc_we`=0, excluding reset.
- `flush_cnt` out CNT_W: number of accepted redirects.

## Operation
- States are RUN, DWAIT and REDIR. State, the wait timer and the counters are registered. All enable and flush outputs are combinational from state and current inputs.
- Actions are evaluated in strict priority order; the first match wins.
  1. **Data wait** (`dmem_req` && !`dmem_ready`): all `*_we`=0, `mem_wb_flush`=1, other flushes 0. Next state is DWAIT. The EX, DE and IF hazard flags are ignored because their stages are frozen.
  2. **Redirect** (`control_haz`): `pc_we`=1, `if_de_flush`=1, `de_ex_flush`=1, remaining enables 1, `imem_abort`=!`imem_ready`. Next state is REDIR. `flush_cnt` increments.
  3. **Load-use** (`load_use_haz` and state != REDIR): `pc_we`=0, `if_de_we`=0, `de_ex_flush`=1, `de_ex_we`=1, `ex_mem_we`=1.
  4. **Fetch miss** (!`imem_ready`): `pc_we`=0, `if_de_flush`=1, all downstream enables 1.
  5. **Normal**: all enables 1, all flushes 0.
- Any cycle not matching Data wait or Redirect sets the next state to RUN.
- REDIR lasts exactly one cycle. It masks `load_use_haz` because DE holds a bubble whose address fields may be stale. Data wait, Redirect and Fetch miss are still honoured in REDIR.
- In DWAIT, the cycle with `dmem_ready`=1 is evaluated through priority items 2–5, so the pipeline advances that cycle.
- Wait timer: cleared on entry to DWAIT, incremented on each DWAIT cycle. When it reaches `TIMEOUT`, `mem_timeout` sets and stays set until `RST`. The stall itself continues regardless.
- Counters saturate at all-ones. `cnt_clr` has priority over increment. `stall_cnt` increments on each cycle with `pc_we`=0 and `RST`=0.

## Timing
- Reset values: state=RUN, timer=0, `stall_cnt`=0, `flush_cnt`=0, `mem_timeout`=0.
- While `RST`=1, outputs are forced regardless of state: all `*_we`=0, all three flushes=1, `imem_abort`=1.
- Hazard to enable/flush latency is 0 cycles (same cycle). The state reflects a hazard 1 cycle later.
- Reset mid-DWAIT or mid-REDIR returns to RUN on the next edge with no further stall.
- `control_haz` held across a DWAIT is applied exactly once, in the release cycle.
- `control_haz` and `load_use_haz` together: only the redirect is applied.
- `control_haz` and !`imem_ready` together: redirect is applied with `imem_abort`=1 for that one cycle.

## Test plan
- **Reset, then idle.** Hold `RST` for 2 cycles, then run with all hazards 0 and readies 1. Expect all `*_we`=1, all flushes 0, `stall_cnt`=0 after 10 cycles.
- **Single load-use.** Pulse `load_use_haz` for 1 cycle. Expect `pc_we`=0, `if_de_we`=0, `de_ex_flush`=1 that cycle only, and `stall_cnt`=1.
- **Redirect with load-use.** Assert `control_haz` and `load_use_haz` together, then `load_use_haz` alone on the next cycle. Expect both flushes=1 and `pc_we`=1 in cycle 1. In cycle 2 (REDIR), expect no stall. `flush_cnt`=1.
- **Data wait with pending redirect.** Hold `dmem_req`=1 with `dmem_ready`=0 for 3 cycles, `control_haz`=1 throughout. Expect 3 frozen cycles with `mem_wb_flush`=1, the redirect in the release cycle, `flush_cnt`=1, `stall_cnt`=3.
- **Watchdog.** With `TIMEOUT`=4, hold a data wait for 6 cycles. Expect `mem_timeout` to rise on the cycle after the 4th DWAIT cycle and stay high. Release `dmem_ready`; expect `mem_timeout` to stay high until `RST`.
- **Counter saturation and clear.** With `CNT_W`=4, apply 20 load-use cycles. Expect `stall_cnt`=15. Assert `cnt_clr` alongside another stall; expect `stall_cnt`=0.
